// File: rtl/mem_ctrl_arb_pkg.sv
// Shared sizes, state encoding and address helper for the main-memory controller.
package mem_ctrl_arb_pkg;

  localparam int PA_WIDTH  = 16;
  localparam int BLK_WIDTH = 128;
  localparam int BYTE      = 8;
  localparam int BLK_BYTES = BLK_WIDTH / BYTE;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_ISSUE,
    MC_WAIT,
    MC_RESP
  } mc_state_t;

  function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] addr);
    return addr & ~PA_WIDTH'(BLK_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Two-port memory controller: one block transaction at a time to main memory,
// round-robin between requesters, fixed access latency before the ack.
//
// state    | meaning
// MC_IDLE  | waiting for a request, winner registered on exit
// MC_ISSUE | single-cycle rd_en/wr_en pulse to memory
// MC_WAIT  | counting down the memory latency, read data captured on last cycle
// MC_RESP  | one-cycle ack to the granted requester
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [PA_WIDTH-1:0]  addr0,
  input  logic [PA_WIDTH-1:0]  addr1,
  input  logic [BLK_WIDTH-1:0] wdata0,
  input  logic [BLK_WIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [BLK_WIDTH-1:0] rdata,
  output logic                 busy,
  output logic                 gnt_id,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_ctrl_arb: LATENCY must be in 1..15");
  end

  mc_state_t            state;
  logic [3:0]           cnt;
  logic                 rr_last;
  logic                 we_r;
  logic                 arb_valid;
  logic                 arb_winner;
  logic                 sel_we;
  logic [PA_WIDTH-1:0]  sel_addr;
  logic [BLK_WIDTH-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (rr_last),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign sel_we    = arb_winner ? we1    : we0;
  assign sel_addr  = arb_winner ? addr1  : addr0;
  assign sel_wdata = arb_winner ? wdata1 : wdata0;
  assign busy      = (state != MC_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= MC_IDLE;
      cnt         <= '0;
      rr_last     <= 1'b1;
      gnt_id      <= 1'b0;
      we_r        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rdata       <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      unique case (state)
        MC_IDLE: begin
          if (arb_valid) begin
            gnt_id      <= arb_winner;
            we_r        <= sel_we;
            mem_addr    <= blk_align(sel_addr);
            mem_wr_data <= sel_wdata;
            mem_rd_en   <= ~sel_we;
            mem_wr_en   <= sel_we;
            state       <= MC_ISSUE;
          end
        end
        MC_ISSUE: begin
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          cnt       <= 4'(LATENCY);
          state     <= MC_WAIT;
        end
        MC_WAIT: begin
          cnt <= cnt - 4'd1;
          // memory read data is stable from the cycle after rd_en until the next access
          if (cnt == 4'd1) begin
            if (!we_r) rdata <= mem_rd_data;
            ack0  <= ~gnt_id;
            ack1  <= gnt_id;
            state <= MC_RESP;
          end
        end
        MC_RESP: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          rr_last <= gnt_id;
          state   <= MC_IDLE;
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule
